// File: rtl/sd_tx_pkg.sv
// sd_tx_pkg
//   Shared definitions for the SD TX serializer: FSM state encoding,
//   CRC16 polynomial, shift cycles per 32-bit word in each bus mode, the
//   idle DAT line value, and the byte-reversal helper used when
//   SD_TX_BYTE_SWAP_EN is defined.
package sd_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_CRC   = 3'd4,
    ST_END   = 3'd5,
    ST_DONE  = 3'd6
  } sd_tx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  localparam int unsigned CYC_WORD_1B = 32;
  localparam int unsigned CYC_WORD_4B = 8;

  localparam logic [3:0] DAT_IDLE = 4'hF;

  // Little-endian memory byte 0 ends up in bits [31:24], so it goes out first.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sd_tx_serializer_crc16.sv
// sd_crc16
//   Bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT line.
//   Ports:
//     sd_clk  in   clock
//     rst     in   async active-low reset, clears the CRC
//     clr     in   synchronous clear (start of a new block)
//     en      in   fold din into the CRC this cycle
//     din     in   line bit being transmitted
//     crc     out  current CRC value
module sd_crc16
  import sd_tx_pkg::*;
(
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = din ^ crc_q[15];
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) crc_q <= '0;
    else      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_tx_serializer.sv
// sd_tx_serializer
//   Pops 32-bit words from the TX FIFO and serialises one SD data block on
//   DAT (1-bit or 4-bit): start bit, payload MSB first, per-line CRC16, end
//   bit. Raises stall when the FIFO runs dry mid-block so sd_clk can be gated.
//   Optional build macro: SD_TX_BYTE_SWAP_EN -- byte-reverse each FIFO word
//   on load so little-endian byte 0 is transmitted first.
//   Ports:
//     sd_clk      in   SD card clock (sole clock)
//     rst         in   async active-low reset
//     start       in   one-cycle pulse, begin a block (ignored unless idle)
//     bus_4bit    in   1 = DAT[3:0], 0 = DAT0 only; sampled on start
//     blk_size    in   block length in bytes; sampled on start
//     fifo_q      in   FIFO read data, valid the cycle after fifo_rd
//     fifo_empty  in   FIFO empty flag
//     fifo_rd     out  FIFO pop strobe
//     sd_dat_o    out  DAT line drive values
//     sd_dat_oe   out  DAT output enable
//     stall       out  FIFO underrun, request sd_clk freeze
//     busy        out  block in progress
//     done        out  one-cycle pulse after the end bit
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | popping the first word of the block
//   START | start bit on the active lines
//   DATA  | shifting payload, prefetching the next word
//   CRC   | 16 CRC bits per active line
//   END   | end bit, all lines high
//   DONE  | done pulse, back to IDLE
module sd_tx_serializer
  import sd_tx_pkg::*;
#(
  parameter int unsigned BLK_W = 12
) (
  input  logic             sd_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bus_4bit,
  input  logic [BLK_W-1:0] blk_size,
  input  logic [31:0]      fifo_q,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [3:0]       sd_dat_o,
  output logic             sd_dat_oe,
  output logic             stall,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] LAST_1B = 5'(CYC_WORD_1B - 1);
  localparam logic [4:0] LAST_4B = 5'(CYC_WORD_4B - 1);

  sd_tx_state_e     state_q, state_d;
  logic             bus4_q, bus4_d;
  // Words not yet popped from the FIFO.
  logic [BLK_W-1:0] words_left_q, words_left_d;
  logic [31:0]      shreg_q, shreg_d;
  logic [31:0]      nxt_word_q, nxt_word_d;
  logic             nxt_valid_q, nxt_valid_d;
  logic             rd_pend_q, rd_pend_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;

  logic [31:0]      word_in;
  logic [4:0]       cyc_last;
  logic [3:0]       cur_bits;
  logic [3:0]       crc_bits;
  logic             have_next;
  logic             last_word;
  logic             need_word;
  logic             hold;
  logic             crc_en;
  logic             crc_clr;
  logic [15:0]      crc_val [4];

`ifdef SD_TX_BYTE_SWAP_EN
  assign word_in = byte_swap32(fifo_q);
`else
  assign word_in = fifo_q;
`endif

  assign cyc_last  = bus4_q ? LAST_4B : LAST_1B;
  assign cur_bits  = bus4_q ? shreg_q[31:28] : {3'b111, shreg_q[31]};
  assign have_next = nxt_valid_q | rd_pend_q;
  assign last_word = (words_left_q == '0) && !have_next;
  assign need_word = (words_left_q != '0) && !have_next;
  // Last bit of a word is on the lines but its successor has not arrived.
  assign hold      = (bit_cnt_q == 5'd0) && need_word;
  assign crc_clr   = (state_q == ST_IDLE) && start;
  assign crc_en    = (state_q == ST_DATA) && !hold;

  always_comb begin
    crc_bits = '0;
    for (int i = 0; i < 4; i++) begin
      crc_bits[i] = crc_val[i][crc_cnt_q];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_crc
    localparam bit LINE0 = (g == 0);
    sd_crc16 u_crc (
      .sd_clk (sd_clk),
      .rst    (rst),
      .clr    (crc_clr),
      .en     (crc_en && (bus4_q || LINE0)),
      .din    (cur_bits[g]),
      .crc    (crc_val[g])
    );
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (blk_size >> 2) == '0 ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: if (rd_pend_q) state_d = ST_START;
      ST_START: state_d = ST_DATA;
      ST_DATA:  if (bit_cnt_q == 5'd0 && last_word) state_d = ST_CRC;
      ST_CRC:   if (crc_cnt_q == 4'd0) state_d = ST_END;
      ST_END:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd   = 1'b0;
    stall     = 1'b0;
    sd_dat_o  = DAT_IDLE;
    sd_dat_oe = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_FETCH: begin
        busy    = 1'b1;
        fifo_rd = !rd_pend_q && !fifo_empty;
        stall   = !rd_pend_q && fifo_empty;
      end
      ST_START: begin
        busy      = 1'b1;
        sd_dat_oe = 1'b1;
        sd_dat_o  = bus4_q ? 4'h0 : 4'hE;
      end
      ST_DATA: begin
        busy      = 1'b1;
        sd_dat_oe = 1'b1;
        sd_dat_o  = cur_bits;
        // Prefetch window opens two cycles before the last shift cycle and
        // stays open through any hold until the pop is issued.
        if (need_word && bit_cnt_q <= 5'd2) begin
          fifo_rd = !fifo_empty;
          stall   = fifo_empty;
        end
      end
      ST_CRC: begin
        busy      = 1'b1;
        sd_dat_oe = 1'b1;
        sd_dat_o  = bus4_q ? crc_bits : {3'b111, crc_bits[0]};
      end
      ST_END: begin
        busy      = 1'b1;
        sd_dat_oe = 1'b1;
        sd_dat_o  = DAT_IDLE;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bus4_d       = bus4_q;
    words_left_d = words_left_q;
    shreg_d      = shreg_q;
    nxt_word_d   = nxt_word_q;
    nxt_valid_d  = nxt_valid_q;
    rd_pend_d    = fifo_rd;
    bit_cnt_d    = bit_cnt_q;
    crc_cnt_d    = crc_cnt_q;

    if (fifo_rd) words_left_d = words_left_q - BLK_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        nxt_valid_d = 1'b0;
        if (start) begin
          bus4_d       = bus_4bit;
          words_left_d = blk_size >> 2;
        end
      end
      ST_FETCH: begin
        if (rd_pend_q) begin
          shreg_d   = word_in;
          bit_cnt_d = cyc_last;
        end
      end
      ST_DATA: begin
        crc_cnt_d = 4'd15;
        if (bit_cnt_q != 5'd0) begin
          // Word arrives before the current one is exhausted: park it.
          if (rd_pend_q) begin
            nxt_word_d  = word_in;
            nxt_valid_d = 1'b1;
          end
          shreg_d   = bus4_q ? {shreg_q[27:0], 4'h0} : {shreg_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 5'd1;
        end else if (nxt_valid_q) begin
          shreg_d     = nxt_word_q;
          nxt_valid_d = 1'b0;
          bit_cnt_d   = cyc_last;
        end else if (rd_pend_q) begin
          shreg_d   = word_in;
          bit_cnt_d = cyc_last;
        end
      end
      ST_CRC: crc_cnt_d = crc_cnt_q - 4'd1;
      default: ;
    endcase
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      bus4_q       <= 1'b0;
      words_left_q <= '0;
      shreg_q      <= '0;
      nxt_word_q   <= '0;
      nxt_valid_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      bit_cnt_q    <= '0;
      crc_cnt_q    <= '0;
    end else begin
      bus4_q       <= bus4_d;
      words_left_q <= words_left_d;
      shreg_q      <= shreg_d;
      nxt_word_q   <= nxt_word_d;
      nxt_valid_q  <= nxt_valid_d;
      rd_pend_q    <= rd_pend_d;
      bit_cnt_q    <= bit_cnt_d;
      crc_cnt_q    <= crc_cnt_d;
    end
  end

endmodule

// File: tb/tb_sd_tx_serializer.sv
module tb_sd_tx_serializer;

  localparam int BLK_W = 12;

  logic             sd_clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             bus_4bit = 1'b0;
  logic [BLK_W-1:0] blk_size = '0;
  logic [31:0]      fifo_q = '0;
  logic             fifo_empty;
  logic             empty_r = 1'b1;
  logic             force_empty = 1'b0;
  logic             fifo_rd;
  logic [3:0]       sd_dat_o;
  logic             sd_dat_oe;
  logic             stall;
  logic             busy;
  logic             done;

  always #5 sd_clk = ~sd_clk;

  assign fifo_empty = force_empty | empty_r;

  sd_tx_serializer #(.BLK_W(BLK_W)) dut (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .start      (start),
    .bus_4bit   (bus_4bit),
    .blk_size   (blk_size),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .sd_dat_o   (sd_dat_o),
    .sd_dat_oe  (sd_dat_oe),
    .stall      (stall),
    .busy       (busy),
    .done       (done)
  );

  // FIFO model: data valid the cycle after the pop.
  logic [31:0] fifo_mem[$];
  always @(posedge sd_clk) begin
    if (fifo_rd && fifo_mem.size() != 0) fifo_q <= fifo_mem.pop_front();
    empty_r <= (fifo_mem.size() == 0);
  end

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic [3:0]  exp_q[$];
  chk_t        chk_q[$];
  logic [31:0] blk_words[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, rd_cnt = 0, stall_cnt = 0, oe_cnt = 0, done_cnt = 0, held_cnt = 0;
  int last_oe_cyc = 0, done_cyc = 0, sym_idx = 0;
  logic [3:0] last_acc = 4'hF;
  logic [3:0] mon_e;
  chk_t       mon_c;
  bit chk_en = 1'b1;
  bit allow_hold = 1'b0;

  // Monitor: counts line events and pops both the symbol scoreboard and
  // the end-of-block check queue.
  always @(negedge sd_clk) begin
    cyc++;
    if (rst) begin
      if (fifo_rd) rd_cnt++;
      if (stall) stall_cnt++;
      if (sd_dat_oe) begin
        oe_cnt++;
        last_oe_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (chk_en && sd_dat_oe) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stream_extra: dat=%h with nothing expected", sd_dat_o);
        end else if (allow_hold && sd_dat_o !== exp_q[0] && sd_dat_o === last_acc) begin
          held_cnt++;
        end else begin
          mon_e = exp_q.pop_front();
          n_cmp++;
          if (sd_dat_o !== mon_e) begin
            n_err++;
            $display("FAIL stream[%0d]: dat=%h expected %h", sym_idx, sd_dat_o, mon_e);
          end
          last_acc = mon_e;
          sym_idx++;
        end
      end
    end
    while (chk_q.size() != 0) begin
      mon_c = chk_q.pop_front();
      n_cmp++;
      if (mon_c.act !== mon_c.exp) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sd_clk);
    #1;
  endtask

  task automatic req(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    c  = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  task automatic build_exp(input bit b4, output int nsym);
    logic [15:0] crc[4];
    logic [31:0] w;
    logic [3:0]  nib;
    for (int i = 0; i < 4; i++) crc[i] = '0;
    nsym = 0;
    exp_q.push_back(b4 ? 4'h0 : 4'hE); nsym++;
    foreach (blk_words[n]) begin
      w = blk_words[n];
`ifdef SD_TX_BYTE_SWAP_EN
      w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
      if (b4) begin
        for (int k = 0; k < 8; k++) begin
          nib = w[31-4*k -: 4];
          exp_q.push_back(nib); nsym++;
          for (int i = 0; i < 4; i++) crc[i] = crc_step(crc[i], nib[i]);
        end
      end else begin
        for (int b = 0; b < 32; b++) begin
          exp_q.push_back({3'b111, w[31-b]}); nsym++;
          crc[0] = crc_step(crc[0], w[31-b]);
        end
      end
    end
    for (int j = 15; j >= 0; j--) begin
      if (b4) exp_q.push_back({crc[3][j], crc[2][j], crc[1][j], crc[0][j]});
      else    exp_q.push_back({3'b111, crc[0][j]});
      nsym++;
    end
    exp_q.push_back(4'hF); nsym++;
  endtask

  task automatic run_block(input string tag, input bit b4, input int bytes,
                           input int exp_rd, input int exp_stall, input int exp_hold);
    int rd0, st0, oe0, dn0, hd0, nsym, g;
    rd0 = rd_cnt; st0 = stall_cnt; oe0 = oe_cnt; dn0 = done_cnt; hd0 = held_cnt;
    foreach (blk_words[n]) fifo_mem.push_back(blk_words[n]);
    nsym = 0;
    if (bytes >= 4) build_exp(b4, nsym);
    bus_4bit = b4;
    blk_size = BLK_W'(bytes);
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
    g = 0;
    while (done_cnt == dn0 && g < 10000) begin
      tick(1);
      g++;
    end
    if (g >= 10000) begin
      req({tag, "_timeout"}, 64'(g), 64'd0);
      rst = 1'b0; tick(2); rst = 1'b1;
      exp_q.delete();
      fifo_mem.delete();
    end
    tick(2);
    req({tag, "_fifo_rd"}, 64'(rd_cnt - rd0), 64'(exp_rd));
    req({tag, "_stall"},   64'(stall_cnt - st0), 64'(exp_stall));
    req({tag, "_oe_cyc"},  64'(oe_cnt - oe0), 64'(nsym + exp_hold));
    req({tag, "_held"},    64'(held_cnt - hd0), 64'(exp_hold));
    req({tag, "_done"},    64'(done_cnt - dn0), 64'd1);
    req({tag, "_left"},    64'(exp_q.size()), 64'd0);
    if (nsym > 0) req({tag, "_done_pos"}, 64'(done_cyc), 64'(last_oe_cyc + 1));
    tick(1);
  endtask

  task automatic inject_underrun();
    int g;
    g = 0;
    while (!sd_dat_oe && g < 200) begin
      tick(1);
      g++;
    end
    tick(6);  // START + 5 data cycles: now at the second-word prefetch point
    force_empty = 1'b1;
    tick(5);
    force_empty = 1'b0;
  endtask

  initial begin
    int g;
    rst = 1'b0;
    tick(3);
    req("reset_outputs", 64'({fifo_rd, sd_dat_o, sd_dat_oe, stall, busy, done}), 64'h0F0);
    rst = 1'b1;
    tick(2);

    blk_words = '{32'h0000_0000, 32'h8000_0001};
    run_block("t1_1bit_8", 1'b0, 8, 2, 0, 0);

    blk_words = '{32'hA5C3_F00F};
    run_block("t2_4bit_4", 1'b1, 4, 1, 0, 0);

    blk_words.delete();
    for (int i = 0; i < 128; i++) blk_words.push_back(32'h0);
    run_block("t3_zero_512", 1'b0, 512, 128, 0, 0);

    blk_words = '{32'h1234_5678, 32'h9ABC_DEF0};
    allow_hold = 1'b1;
    fork
      run_block("t4_underrun", 1'b1, 8, 2, 5, 4);
      inject_underrun();
    join
    allow_hold = 1'b0;

    blk_words.delete();
    run_block("t5_short", 1'b0, 3, 0, 0, 0);

    // Reset mid-DATA: abort, check reset values immediately, then a clean block.
    chk_en = 1'b0;
    fifo_mem.push_back(32'h0BAD_F00D);
    fifo_mem.push_back(32'h7777_1111);
    bus_4bit = 1'b1;
    blk_size = BLK_W'(8);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    g = 0;
    while (!sd_dat_oe && g < 200) begin
      tick(1);
      g++;
    end
    tick(10);
    rst = 1'b0;
    #1;
    req("rst_mid_outputs", 64'({fifo_rd, sd_dat_o, sd_dat_oe, stall, busy, done}), 64'h0F0);
    tick(2);
    fifo_mem.delete();
    tick(1);
    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    blk_words = '{32'hCAFE_BABE, 32'h0F1E_2D3C};
    run_block("t6_after_rst", 1'b1, 8, 2, 0, 0);

    blk_words = '{32'h1122_3344};
    run_block("t7_4bit_swapchk", 1'b1, 4, 1, 0, 0);

    blk_words = '{32'hDEAD_BEEF};
    run_block("t8_1bit_4", 1'b0, 4, 1, 0, 0);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
